// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// Module      : bcd_pkg
// Description : Shared BCD constants and the sequencer state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_SIX  = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_unit.sv
//------------------------------------------------------------------------------
// Module      : bcd_digit_unit
// Description : Combinational single-digit BCD adder / nines-complement subtractor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_unit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic [BCD_W-1:0] d,
    output logic             cout
);

    logic [BCD_W-1:0] w_y;
    logic [BCD_W:0]   w_sum;

    always_comb begin
        w_y   = sub ? (BCD_NINE - y) : y;
        w_sum = {1'b0, x} + {1'b0, w_y} + {{BCD_W{1'b0}}, cin};
        // Binary sums 10..19 wrap to the BCD digit by adding six.
        if (w_sum > {1'b0, BCD_NINE}) begin
            cout = 1'b1;
            d    = w_sum[BCD_W-1:0] + BCD_SIX;
        end else begin
            cout = 1'b0;
            d    = w_sum[BCD_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd3_addsub_seq.sv
//------------------------------------------------------------------------------
// Module      : bcd3_addsub_seq
// Description : Signed sign-magnitude BCD add/subtract, one digit per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd3_addsub_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a_sign,
    input  logic [4*NDIG-1:0] a_mag,
    input  logic              b_sign,
    input  logic [4*NDIG-1:0] b_mag,
    input  logic              op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              r_sign,
    output logic [4*NDIG-1:0] r_mag,
    output logic              ovf,
    output logic              err
);

    localparam int          IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    state_t              r_state;
    logic [4*NDIG-1:0]   r_a;
    logic [4*NDIG-1:0]   r_b;
    logic                r_a_sign;
    logic                r_eff_sub;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_res_sign;
    logic [4*NDIG-1:0]   r_res_mag;
    logic                r_ovf;
    logic                r_err;

    logic                w_in_bad;
    logic [BCD_W-1:0]    w_x;
    logic [BCD_W-1:0]    w_y;
    logic                w_sub;
    logic [BCD_W-1:0]    w_d;
    logic                w_cout;
    logic [4*NDIG-1:0]   w_mag_next;

    always_comb begin
        w_in_bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (a_mag[4*k +: 4] > BCD_NINE || b_mag[4*k +: 4] > BCD_NINE) begin
                w_in_bad = 1'b1;
            end
        end
    end

    // The second pass swaps operand roles to form B - A.
    always_comb begin
        w_x        = '0;
        w_y        = '0;
        w_mag_next = r_res_mag;
        for (int k = 0; k < NDIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_x                 = (r_state == PASS2) ? r_b[4*k +: 4] : r_a[4*k +: 4];
                w_y                 = (r_state == PASS2) ? r_a[4*k +: 4] : r_b[4*k +: 4];
                w_mag_next[4*k +: 4] = w_d;
            end
        end
        w_sub = (r_state == PASS2) ? 1'b1 : r_eff_sub;
    end

    bcd_digit_unit u_digit (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .sub  (w_sub),
        .d    (w_d),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_a_sign    <= 1'b0;
            r_eff_sub   <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res_sign  <= 1'b0;
            r_res_mag   <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a_mag;
                        r_b        <= b_mag;
                        r_a_sign   <= a_sign;
                        r_eff_sub  <= a_sign ^ b_sign ^ op;
                        r_carry    <= a_sign ^ b_sign ^ op;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_res_sign <= 1'b0;
                        r_res_mag  <= '0;
                        r_ovf      <= 1'b0;
                        if (w_in_bad) begin
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= PASS1;
                        end
                    end
                end
                PASS1, PASS2: begin
                    r_res_mag <= w_mag_next;
                    r_carry   <= w_cout;
                    if (r_idx == LAST) begin
                        r_idx <= '0;
                        if (r_state == PASS1 && r_eff_sub && !w_cout) begin
                            // No end-around carry: |A| < |B|, redo as B - A.
                            r_carry <= 1'b1;
                            r_state <= PASS2;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            if (r_state == PASS2) begin
                                r_res_sign <= ~r_a_sign;
                                r_ovf      <= 1'b0;
                            end else if (!r_eff_sub && w_cout) begin
                                r_res_sign <= r_a_sign;
                                r_ovf      <= 1'b1;
                            end else begin
                                r_res_sign <= (w_mag_next == '0) ? 1'b0 : r_a_sign;
                                r_ovf      <= 1'b0;
                            end
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign r_sign    = r_res_sign;
    assign r_mag     = r_res_mag;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd3_addsub_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd3_addsub_seq
// Description : Self-checking bench for bcd3_addsub_seq with an integer reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd3_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign;
    logic [11:0] a_mag;
    logic        b_sign;
    logic [11:0] b_mag;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic        r_sign;
    logic [11:0] r_mag;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd3_addsub_seq #(.NDIG(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .a_mag     (a_mag),
        .b_sign    (b_sign),
        .b_mag     (b_mag),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_sign    (r_sign),
        .r_mag     (r_mag),
        .ovf       (ovf),
        .err       (err)
    );

    // Reference: signed integer arithmetic; result packed {sign, mag[11:0], ovf, err}.
    function automatic void ref_model(input logic as_, input logic [11:0] am, input logic bs_,
                                      input logic [11:0] bm, input logic op_,
                                      output logic [14:0] exp_res, output int exp_lat);
        int  va, vb, res, mag, m;
        bit  bad;
        logic es;
        logic [11:0] em;
        bad = 0;
        for (int d = 0; d < 3; d++) begin
            if (am[4*d +: 4] > 9 || bm[4*d +: 4] > 9) bad = 1;
        end
        if (bad) begin
            exp_res = {1'b0, 12'h000, 1'b0, 1'b1};
            exp_lat = 1;
            return;
        end
        va  = am[3:0] + 10 * am[7:4] + 100 * am[11:8];
        vb  = bm[3:0] + 10 * bm[7:4] + 100 * bm[11:8];
        if (as_) va = -va;
        if (bs_) vb = -vb;
        res = op_ ? (va - vb) : (va + vb);
        mag = (res < 0) ? -res : res;
        m   = mag % 1000;
        em  = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
        es  = (mag > 999) ? as_ : (res < 0);
        exp_res = {es, em, (mag > 999), 1'b0};
        // Two passes exactly when an effective subtraction has |A| < |B|.
        if ((as_ ^ bs_ ^ op_) && ((va < 0 ? -va : va) < (vb < 0 ? -vb : vb)))
            exp_lat = 7;
        else
            exp_lat = 4;
    endfunction

    // Drives one operation starting just after a negedge; returns observations.
    task automatic exec_op(input logic as_, input logic [11:0] am, input logic bs_,
                           input logic [11:0] bm, input logic op_, input bit ack,
                           output int wait_c, output int lat, output logic [14:0] obs,
                           output logic v_after, output logic r_after);
        wait_c = 0;
        while (in_ready !== 1'b1 && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        in_valid = 1'b1;
        a_sign   = as_;
        a_mag    = am;
        b_sign   = bs_;
        b_mag    = bm;
        op       = op_;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        obs = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        obs     = {r_sign, r_mag, ovf, err};
        v_after = 1'bx;
        r_after = 1'bx;
        if (ack) begin
            out_ready = 1'b1;
            @(negedge clk);
            v_after   = out_valid;
            r_after   = in_ready;
            out_ready = 1'b0;
        end
    endtask

    task automatic run_and_check(input string name, input logic as_, input logic [11:0] am,
                                 input logic bs_, input logic [11:0] bm, input logic op_);
        int w, lat, elat;
        logic [14:0] obs, exp_r;
        logic va, ra;
        ref_model(as_, am, bs_, bm, op_, exp_r, elat);
        exec_op(as_, am, bs_, bm, op_, 1'b1, w, lat, obs, va, ra);
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL %s result {sign,mag,ovf,err}: got %b_%h_%b_%b expected %b_%h_%b_%b",
                     name, obs[14], obs[13:2], obs[1], obs[0],
                     exp_r[14], exp_r[13:2], exp_r[1], exp_r[0]);
        end
        n_checks++;
        if ({va, ra} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s after handshake {out_valid,in_ready}: got %b%b expected 01", name, va, ra);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_sign = 0; a_mag = '0; b_sign = 0; b_mag = '0; op = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, r_sign, r_mag, ovf, err} !== {1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset values: got rdy=%b vld=%b s=%b mag=%h ovf=%b err=%b expected 1 0 0 000 0 0",
                     in_ready, out_valid, r_sign, r_mag, ovf, err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_and_check("add_123_456",  1'b0, 12'h123, 1'b0, 12'h456, 1'b0);
        run_and_check("sub_500_123",  1'b0, 12'h500, 1'b0, 12'h123, 1'b1);
        run_and_check("sub_123_500",  1'b0, 12'h123, 1'b0, 12'h500, 1'b1);
        run_and_check("add_n123_500", 1'b1, 12'h123, 1'b0, 12'h500, 1'b0);
        run_and_check("ovf_n999_n1",  1'b1, 12'h999, 1'b1, 12'h001, 1'b0);
        run_and_check("ovf_999_1",    1'b0, 12'h999, 1'b0, 12'h001, 1'b0);
        run_and_check("zero_250",     1'b0, 12'h250, 1'b1, 12'h250, 1'b0);
        run_and_check("zero_neg",     1'b1, 12'h250, 1'b1, 12'h250, 1'b1);
        run_and_check("err_1A3",      1'b0, 12'h1A3, 1'b0, 12'h456, 1'b0);
        run_and_check("err_bF00",     1'b1, 12'h100, 1'b0, 12'hF00, 1'b1);
    endtask

    task automatic test_random();
        logic [11:0] am, bm;
        for (int n = 0; n < 40; n++) begin
            am = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            bm = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 11) == 0) am[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) bm = am;
            run_and_check("random", 1'($urandom), am, 1'($urandom), bm, 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int w, lat;
        logic [14:0] obs;
        logic va, ra;
        exec_op(1'b0, 12'h001, 1'b0, 12'h002, 1'b0, 1'b1, w, lat, obs, va, ra);
        exec_op(1'b0, 12'h010, 1'b1, 12'h020, 1'b0, 1'b1, w, lat, obs, va, ra);
        n_checks++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL back_to_back accept delay: got %0d cycles expected 0", w);
        end
        n_checks++;
        if (obs !== {1'b1, 12'h010, 1'b0, 1'b0} || lat !== 7) begin
            n_fail++;
            $display("FAIL back_to_back second result: got %h lat %0d expected %h lat 7",
                     obs, lat, {1'b1, 12'h010, 1'b0, 1'b0});
        end
    endtask

    task automatic test_hold_and_abort();
        int w, lat;
        logic [14:0] obs;
        logic va, ra;
        bit   seen;
        exec_op(1'b0, 12'h321, 1'b0, 12'h111, 1'b0, 1'b0, w, lat, obs, va, ra);
        in_valid = 1'b1;
        a_mag    = 12'h999;
        b_mag    = 12'h999;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, r_sign, r_mag, ovf, err} !== {1'b1, 1'b0, 1'b0, 12'h432, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got vld=%b rdy=%b s=%b mag=%h ovf=%b err=%b expected 1 0 0 432 0 0",
                         k, out_valid, in_ready, r_sign, r_mag, ovf, err);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        // New operation aborted by reset in its second busy cycle.
        in_valid = 1'b1;
        a_sign = 0; a_mag = 12'h123; b_sign = 0; b_mag = 12'h500; op = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, r_sign, r_mag, ovf, err} !== {1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort reset values: got rdy=%b vld=%b s=%b mag=%h ovf=%b err=%b expected 1 0 0 000 0 0",
                     in_ready, out_valid, r_sign, r_mag, ovf, err);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort emitted result: got out_valid=1 expected none");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold_and_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
